// File: rtl/tick_prescaler_if.sv
// Control/status bundle between a tick_prescaler and whatever programs it.
// The master drives run enable and ratio loads; the slave reports tick and ratio state.
interface tick_prescaler_if #(
   parameter int DIV_W = 8
);
   logic             en;
   logic             div_load;
   logic [DIV_W-1:0] div_val;
   logic             tick;
   logic [DIV_W-1:0] div_act;
   logic             load_pending;
   logic             load_err;

   modport master (
      output en, div_load, div_val,
      input  tick, div_act, load_pending, load_err
   );

   modport slave (
      input  en, div_load, div_val,
      output tick, div_act, load_pending, load_err
   );
endinterface

// File: rtl/tick_prescaler.sv
// Programmable clock-enable generator: one-cycle tick every div_act cycles.
// Ratio changes are held in a shadow register and only take effect at a period boundary.
module tick_prescaler #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   tick_prescaler_if.slave   bus
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             tick_q, tick_d;
   logic             pending_q, pending_d;
   logic             err_q, err_d;

   logic tc;
   logic boundary;
   logic load_ok;

   assign tc       = (cnt_q == div_act_q - DIV_W'(1));
   // Stopped is always a boundary, so loads made while idle apply on the next edge.
   assign boundary = !bus.en || tc;
   assign load_ok  = bus.div_load && (bus.div_val != '0);

   always_comb begin
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      div_act_d = div_act_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      err_d     = bus.div_load && (bus.div_val == '0);

      if (!bus.en) begin
         cnt_d = '0;
      end else if (tc) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      if (boundary) begin
         if (load_ok) begin
            div_act_d = bus.div_val;
            pending_d = 1'b0;
         end else if (pending_q) begin
            div_act_d = shadow_q;
            pending_d = 1'b0;
         end
      end else if (load_ok) begin
         shadow_d  = bus.div_val;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         div_act_q <= DIV_RST;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         div_act_q <= div_act_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign bus.tick         = tick_q;
   assign bus.div_act      = div_act_q;
   assign bus.load_pending = pending_q;
   assign bus.load_err     = err_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Bench for tick_prescaler: directed scenarios plus randomized traffic against
// a period/ratio reference model.
module tb_tick_prescaler;
   localparam int DIV_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   tick_prescaler_if #(.DIV_W(DIV_W)) bus();

   tick_prescaler #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: cycles elapsed in the current period and the ratio in force.
   int m_elapsed;
   int m_ratio;
   int m_shadow;
   bit m_pend;
   bit m_tick;
   bit m_err;

   function automatic void m_reset();
      m_elapsed = 0;
      m_ratio   = 4;
      m_shadow  = 0;
      m_pend    = 1'b0;
      m_tick    = 1'b0;
      m_err     = 1'b0;
   endfunction

   function automatic void m_edge();
      bit period_done;
      bit at_boundary;
      bit good_load;
      if (!rst_n) begin
         m_reset();
         return;
      end
      period_done = bus.en && (m_elapsed + 1 == m_ratio);
      at_boundary = !bus.en || period_done;
      good_load   = bus.div_load && (bus.div_val != 0);
      m_err       = bus.div_load && (bus.div_val == 0);
      m_tick      = period_done;
      m_elapsed   = (bus.en && !period_done) ? m_elapsed + 1 : 0;
      if (at_boundary) begin
         if (good_load) begin
            m_ratio = int'(bus.div_val);
            m_pend  = 1'b0;
         end else if (m_pend) begin
            m_ratio = m_shadow;
            m_pend  = 1'b0;
         end
      end else if (good_load) begin
         m_shadow = int'(bus.div_val);
         m_pend   = 1'b1;
      end
   endfunction

   task automatic clk_edge();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic apply_reset(input logic en_val);
      rst_n        = 1'b0;
      bus.en       = en_val;
      bus.div_load = 1'b0;
      bus.div_val  = '0;
      clk_edge();
      clk_edge();
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.en       = 1'b1;
      bus.div_load = 1'b1;
      bus.div_val  = 8'd9;
      for (int i = 0; i < 2; i++) begin
         clk_edge();
         n_cmp++;
         if ({bus.tick, bus.div_act, bus.load_pending, bus.load_err} !== {1'b0, 8'd4, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold c%0d: got tick=%0b act=%0d pend=%0b err=%0b want 0/4/0/0",
                     i, bus.tick, bus.div_act, bus.load_pending, bus.load_err);
         end
      end
      bus.div_load = 1'b0;
      bus.div_val  = '0;
   endtask

   task automatic test_default_ratio();
      int ticks;
      apply_reset(1'b1);
      ticks = 0;
      for (int i = 1; i <= 13; i++) begin
         clk_edge();
         if (bus.tick) ticks++;
         n_cmp++;
         if (bus.tick !== ((i % 4) == 0)) begin
            n_bad++;
            $display("FAIL default_tick e%0d: got %0b want %0b", i, bus.tick, (i % 4) == 0);
         end
      end
      n_cmp++;
      if (ticks != 3) begin
         n_bad++;
         $display("FAIL default_count: got %0d want 3", ticks);
      end
   endtask

   task automatic test_pending();
      apply_reset(1'b1);
      clk_edge();
      bus.div_load = 1'b1;
      bus.div_val  = 8'd2;
      clk_edge();
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.load_pending, bus.div_act} !== {1'b1, 8'd4}) begin
         n_bad++;
         $display("FAIL pend_set: got pend=%0b act=%0d want 1/4", bus.load_pending, bus.div_act);
      end
      clk_edge();
      n_cmp++;
      if ({bus.tick, bus.load_pending} !== 2'b01) begin
         n_bad++;
         $display("FAIL pend_hold: got tick=%0b pend=%0b want 0/1", bus.tick, bus.load_pending);
      end
      clk_edge();
      n_cmp++;
      if ({bus.tick, bus.load_pending, bus.div_act} !== {1'b1, 1'b0, 8'd2}) begin
         n_bad++;
         $display("FAIL pend_apply: got tick=%0b pend=%0b act=%0d want 1/0/2",
                  bus.tick, bus.load_pending, bus.div_act);
      end
      for (int i = 5; i <= 8; i++) begin
         clk_edge();
         n_cmp++;
         if (bus.tick !== ((i % 2) == 0)) begin
            n_bad++;
            $display("FAIL pend_newrate e%0d: got %0b want %0b", i, bus.tick, (i % 2) == 0);
         end
      end
   endtask

   task automatic test_load_err();
      apply_reset(1'b1);
      clk_edge();
      bus.div_load = 1'b1;
      bus.div_val  = 8'd0;
      clk_edge();
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.load_err, bus.div_act, bus.load_pending} !== {1'b1, 8'd4, 1'b0}) begin
         n_bad++;
         $display("FAIL err_pulse: got err=%0b act=%0d pend=%0b want 1/4/0",
                  bus.load_err, bus.div_act, bus.load_pending);
      end
      clk_edge();
      n_cmp++;
      if (bus.load_err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: got %0b want 0", bus.load_err);
      end
      // edge 4 ticks; queue ratio 3 at edge 5, then a rejected load must keep it pending
      for (int i = 4; i <= 8; i++) begin
         bus.div_load = (i == 5) || (i == 6);
         bus.div_val  = (i == 5) ? 8'd3 : 8'd0;
         clk_edge();
         n_cmp++;
         if (bus.tick !== ((i % 4) == 0)) begin
            n_bad++;
            $display("FAIL err_spacing e%0d: got %0b want %0b", i, bus.tick, (i % 4) == 0);
         end
      end
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.div_act, bus.load_pending} !== {8'd3, 1'b0}) begin
         n_bad++;
         $display("FAIL err_keeps_shadow: got act=%0d pend=%0b want 3/0", bus.div_act, bus.load_pending);
      end
   endtask

   task automatic test_ratio_one();
      apply_reset(1'b0);
      bus.div_load = 1'b1;
      bus.div_val  = 8'd1;
      clk_edge();
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.div_act, bus.tick, bus.load_pending} !== {8'd1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL one_idle_load: got act=%0d tick=%0b pend=%0b want 1/0/0",
                  bus.div_act, bus.tick, bus.load_pending);
      end
      bus.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         clk_edge();
         n_cmp++;
         if (bus.tick !== 1'b1) begin
            n_bad++;
            $display("FAIL one_every c%0d: got %0b want 1", i, bus.tick);
         end
      end
      bus.en = 1'b0;
      clk_edge();
      n_cmp++;
      if (bus.tick !== 1'b0) begin
         n_bad++;
         $display("FAIL one_stop: got %0b want 0", bus.tick);
      end
      bus.en = 1'b1;
      clk_edge();
      n_cmp++;
      if (bus.tick !== 1'b1) begin
         n_bad++;
         $display("FAIL one_restart: got %0b want 1", bus.tick);
      end
      bus.div_load = 1'b1;
      bus.div_val  = 8'd4;
      clk_edge();
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.div_act, bus.load_pending} !== {8'd4, 1'b0}) begin
         n_bad++;
         $display("FAIL one_to_four: got act=%0d pend=%0b want 4/0", bus.div_act, bus.load_pending);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset(1'b1);
      for (int i = 1; i <= 3; i++) begin
         bus.div_load = 1'b1;
         bus.div_val  = (i == 1) ? 8'd3 : (i == 2) ? 8'd5 : 8'd6;
         clk_edge();
      end
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.div_act, bus.load_pending} !== {8'd4, 1'b1}) begin
         n_bad++;
         $display("FAIL b2b_pending: got act=%0d pend=%0b want 4/1", bus.div_act, bus.load_pending);
      end
      clk_edge();
      n_cmp++;
      if ({bus.tick, bus.div_act, bus.load_pending} !== {1'b1, 8'd6, 1'b0}) begin
         n_bad++;
         $display("FAIL b2b_lastwins: got tick=%0b act=%0d pend=%0b want 1/6/0",
                  bus.tick, bus.div_act, bus.load_pending);
      end
      for (int i = 5; i <= 9; i++) clk_edge();
      bus.div_load = 1'b1;
      bus.div_val  = 8'd2;
      clk_edge();
      bus.div_load = 1'b0;
      n_cmp++;
      if ({bus.tick, bus.div_act, bus.load_pending} !== {1'b1, 8'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL b2b_at_boundary: got tick=%0b act=%0d pend=%0b want 1/2/0",
                  bus.tick, bus.div_act, bus.load_pending);
      end
   endtask

   task automatic test_async_reset();
      apply_reset(1'b1);
      clk_edge();
      bus.div_load = 1'b1;
      bus.div_val  = 8'd5;
      clk_edge();
      bus.div_load = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.tick, bus.div_act, bus.load_pending, bus.load_err} !== {1'b0, 8'd4, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL async_mid: got tick=%0b act=%0d pend=%0b err=%0b want 0/4/0/0",
                  bus.tick, bus.div_act, bus.load_pending, bus.load_err);
      end
      rst_n = 1'b1;
      m_reset();
      for (int i = 1; i <= 4; i++) begin
         clk_edge();
         n_cmp++;
         if (bus.tick !== (i == 4)) begin
            n_bad++;
            $display("FAIL async_fullperiod e%0d: got %0b want %0b", i, bus.tick, i == 4);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.tick !== 1'b0) begin
         n_bad++;
         $display("FAIL async_tick_clear: got %0b want 0", bus.tick);
      end
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic test_random();
      apply_reset(1'b1);
      for (int i = 0; i < 800; i++) begin
         bus.en       = ($urandom_range(0, 11) != 0);
         bus.div_load = ($urandom_range(0, 6) == 0);
         bus.div_val  = DIV_W'($urandom_range(0, 7));
         clk_edge();
         n_cmp++;
         if ({bus.tick, bus.div_act, bus.load_pending, bus.load_err} !==
             {m_tick, DIV_W'(m_ratio), m_pend, m_err}) begin
            n_bad++;
            $display("FAIL random c%0d: got tick=%0b act=%0d pend=%0b err=%0b want %0b/%0d/%0b/%0b",
                     i, bus.tick, bus.div_act, bus.load_pending, bus.load_err,
                     m_tick, m_ratio, m_pend, m_err);
         end
      end
      bus.div_load = 1'b0;
   endtask

   initial begin
      bus.en       = 1'b0;
      bus.div_load = 1'b0;
      bus.div_val  = '0;
      m_reset();
      #1;
      test_reset();
      test_default_ratio();
      test_pending();
      test_load_err();
      test_ratio_one();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
